// File: rtl/sram_uart_transmit_pkg.sv
// Shared types for the SRAM-to-UART upload path: controller state encoding,
// frame geometry and the byte-select helper.
package sram_uart_transmit_pkg;

    typedef enum logic [2:0] {
        S_UT_IDLE      = 3'd0,
        S_UT_READ_WAIT = 3'd1,
        S_UT_SEND_HIGH = 3'd2,
        S_UT_WAIT_HIGH = 3'd3,
        S_UT_SEND_LOW  = 3'd4,
        S_UT_WAIT_LOW  = 3'd5,
        S_UT_NEXT      = 3'd6
    } sram_uart_tx_state_type;

    localparam int unsigned SRAM_ADDR_W     = 18;
    localparam int unsigned SRAM_DATA_W     = 16;
    localparam int unsigned UART_FRAME_BITS = 10;

    function automatic logic [7:0] word_byte(input logic [15:0] word, input logic high);
        logic [7:0] sel;
        if (high) begin
            sel = word[15:8];
        end else begin
            sel = word[7:0];
        end
        return sel;
    endfunction

endpackage

// File: rtl/sram_uart_transmit_controller.sv
// 8N1 byte serializer: one start bit, eight data bits LSB first, one stop bit,
// each bit held for BAUD_DIVISOR clocks. Empty is high whenever no frame is on the line.
module uart_transmit_controller
    import sram_uart_transmit_pkg::*;
#(
    parameter int unsigned BAUD_DIVISOR = 434
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Clear,
    input  logic       Load,
    input  logic [7:0] TX_data,
    output logic       Empty,
    output logic       UART_TX_O
);

    localparam logic [0:0] S_TX_IDLE  = 1'b0;
    localparam logic [0:0] S_TX_SHIFT = 1'b1;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIVISOR - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(UART_FRAME_BITS - 1);

    logic [0:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    // Next-state logic for the frame sequencer
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            S_TX_IDLE: begin
                tx_d = 1'b1;
                if (Load) begin
                    state_d = S_TX_SHIFT;
                    tx_d    = 1'b0;
                    baud_d  = 16'd0;
                    bit_d   = 4'd0;
                    shift_d = TX_data;
                end else begin
                    state_d = S_TX_IDLE;
                end
            end
            S_TX_SHIFT: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = 16'd0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_TX_IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        // bits 1..8 carry data, bit 9 is the stop bit
                        if (bit_q < 4'd8) begin
                            tx_d    = shift_q[0];
                            shift_d = {1'b1, shift_q[7:1]};
                        end else begin
                            tx_d = 1'b1;
                        end
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Frame state registers; Clear returns the line high on the next edge
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_TX_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 4'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else if (Clear) begin
            state_q <= S_TX_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 4'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign Empty     = (state_q == S_TX_IDLE);
    assign UART_TX_O = tx_q;

endmodule

// File: rtl/sram_uart_transmit.sv
// Streams SRAM words [Start_address..End_address] out the UART, high byte first.
// Owns the SRAM address bus only while Busy is high; never writes.
module sram_uart_transmit
    import sram_uart_transmit_pkg::*;
#(
    parameter int unsigned BAUD_DIVISOR      = 434,
    parameter int unsigned SRAM_READ_LATENCY = 2
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   Initialize,
    input  logic                   Enable,
    input  logic [SRAM_ADDR_W-1:0] Start_address,
    input  logic [SRAM_ADDR_W-1:0] End_address,
    input  logic [SRAM_DATA_W-1:0] SRAM_read_data,
    output logic [SRAM_ADDR_W-1:0] SRAM_address,
    output logic                   SRAM_we_n,
    output logic                   UART_TX_O,
    output logic                   Busy,
    output logic                   Done
);

    localparam logic [7:0] LAT_LAST = 8'(SRAM_READ_LATENCY);

    sram_uart_tx_state_type state_q, state_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SRAM_ADDR_W-1:0] end_q, end_d;
    logic [SRAM_DATA_W-1:0] word_q, word_d;
    logic [7:0]             lat_q, lat_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   we_n_q;
    logic                   load_s;
    logic [7:0]             tx_byte_s;
    logic                   empty_s;
    logic                   wrap_up_s;

    // The NEXT decision is taken in the cycle the low byte drains, keeping the
    // inter-word gap at 3 + latency and Done one cycle after the line goes idle.
    assign wrap_up_s = ((state_q == S_UT_WAIT_LOW) && empty_s) || (state_q == S_UT_NEXT);

    // Word fetch / byte sequencing
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        end_d     = end_q;
        word_d    = word_q;
        lat_d     = lat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load_s    = 1'b0;
        tx_byte_s = 8'h00;
        case (state_q)
            S_UT_IDLE: begin
                if (Enable) begin
                    if (End_address < Start_address) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = Start_address;
                        end_d   = End_address;
                        lat_d   = 8'd0;
                        busy_d  = 1'b1;
                        state_d = S_UT_READ_WAIT;
                    end
                end else begin
                    state_d = S_UT_IDLE;
                end
            end
            S_UT_READ_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    word_d  = SRAM_read_data;
                    state_d = S_UT_SEND_HIGH;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            S_UT_SEND_HIGH: begin
                load_s    = 1'b1;
                tx_byte_s = word_byte(word_q, 1'b1);
                state_d   = S_UT_WAIT_HIGH;
            end
            S_UT_WAIT_HIGH: begin
                if (empty_s) begin
                    state_d = S_UT_SEND_LOW;
                end else begin
                    state_d = S_UT_WAIT_HIGH;
                end
            end
            S_UT_SEND_LOW: begin
                load_s    = 1'b1;
                tx_byte_s = word_byte(word_q, 1'b0);
                state_d   = S_UT_WAIT_LOW;
            end
            S_UT_WAIT_LOW, S_UT_NEXT: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_UT_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (wrap_up_s) begin
            if (addr_q == end_q) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_UT_IDLE;
            end else begin
                addr_d  = addr_q + 18'd1;
                lat_d   = 8'd0;
                state_d = S_UT_READ_WAIT;
            end
        end else begin
            state_d = state_d;
        end
    end

    // Controller registers; Initialize clears everything below Resetn
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_UT_IDLE;
            addr_q  <= 18'd0;
            end_q   <= 18'd0;
            word_q  <= 16'h0000;
            lat_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_n_q  <= 1'b1;
        end else if (Initialize) begin
            state_q <= S_UT_IDLE;
            addr_q  <= 18'd0;
            end_q   <= 18'd0;
            word_q  <= 16'h0000;
            lat_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            word_q  <= word_d;
            lat_q   <= lat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_n_q  <= 1'b1;
        end
    end

    uart_transmit_controller #(
        .BAUD_DIVISOR(BAUD_DIVISOR)
    ) u_tx (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Clear    (Initialize),
        .Load     (load_s),
        .TX_data  (tx_byte_s),
        .Empty    (empty_s),
        .UART_TX_O(UART_TX_O)
    );

    assign SRAM_address = addr_q;
    assign SRAM_we_n    = we_n_q;
    assign Busy         = busy_q;
    assign Done         = done_q;

endmodule

// File: tb/tb_sram_uart_transmit.sv
// Directed bench for sram_uart_transmit: 2-cycle SRAM model, independent 8N1
// line decoder, hand-computed byte streams and cycle counts (BAUD_DIVISOR = 4).
module tb_sram_uart_transmit;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Initialize;
    logic        Enable;
    logic [17:0] Start_address;
    logic [17:0] End_address;
    logic [15:0] SRAM_read_data;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic        UART_TX_O;
    logic        Busy;
    logic        Done;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem [logic [17:0]];
    logic [15:0] rd_p0, rd_p1;
    logic [7:0]  rx_q[$];
    logic        rx_stop_q[$];
    logic [7:0]  rx_b;
    logic        rx_en = 1'b0;

    sram_uart_transmit #(.BAUD_DIVISOR(4), .SRAM_READ_LATENCY(2)) dut (
        .Clock         (Clock),
        .Resetn        (Resetn),
        .Initialize    (Initialize),
        .Enable        (Enable),
        .Start_address (Start_address),
        .End_address   (End_address),
        .SRAM_read_data(SRAM_read_data),
        .SRAM_address  (SRAM_address),
        .SRAM_we_n     (SRAM_we_n),
        .UART_TX_O     (UART_TX_O),
        .Busy          (Busy),
        .Done          (Done)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] sram_rd(input logic [17:0] a);
        if (mem.exists(a)) return mem[a];
        else return 16'h0000;
    endfunction

    // two-cycle read pipeline
    always @(posedge Clock) begin
        rd_p0 <= sram_rd(SRAM_address);
        rd_p1 <= rd_p0;
    end
    assign SRAM_read_data = rd_p1;

    // 8N1 line decoder sampling mid-bit on falling clock edges
    initial begin
        forever begin
            @(negedge Clock);
            if (rx_en && UART_TX_O === 1'b0) begin
                repeat (2) @(negedge Clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge Clock);
                    rx_b[i] = UART_TX_O;
                end
                repeat (4) @(negedge Clock);
                rx_q.push_back(rx_b);
                rx_stop_q.push_back(UART_TX_O);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return {24'h0, rx_q[i]};
        else return 32'hFFFF_FFFF;
    endfunction

    function automatic int bad_stops();
        int n = 0;
        foreach (rx_stop_q[i]) if (rx_stop_q[i] !== 1'b1) n++;
        return n;
    endfunction

    task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
        check_val({tag, "_nbytes"}, rx_q.size(), exp.size());
        foreach (exp[i]) check_val($sformatf("%s_byte%0d", tag, i), rx_at(i), {24'h0, exp[i]});
        check_val({tag, "_stopbits"}, bad_stops(), 0);
        rx_q.delete();
        rx_stop_q.delete();
    endtask

    task automatic run_xfer(input logic [17:0] sa, input logic [17:0] ea, input int budget,
                            output int busy_cyc, output int done_cnt, output int done_at,
                            output int first_low, output logic addr_ok, output logic we_ok);
        logic [17:0] prev;
        @(negedge Clock);
        Start_address = sa;
        End_address   = ea;
        Enable        = 1'b1;
        @(negedge Clock);
        Enable    = 1'b0;
        busy_cyc  = 0;
        done_cnt  = 0;
        done_at   = -1;
        first_low = -1;
        addr_ok   = 1'b1;
        we_ok     = 1'b1;
        prev      = SRAM_address;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) @(negedge Clock);
            if (Busy) busy_cyc++;
            if (UART_TX_O === 1'b0 && first_low < 0) first_low = c - 1;
            if (SRAM_we_n !== 1'b1) we_ok = 1'b0;
            if (SRAM_address != prev && SRAM_address != prev + 18'd1) addr_ok = 1'b0;
            prev = SRAM_address;
            if (Done) begin
                done_cnt++;
                done_at = c;
                break;
            end
        end
        @(negedge Clock);
        if (Done) done_cnt++;
    endtask

    int   busy_cyc, done_cnt, done_at, first_low, seen;
    logic addr_ok, we_ok;
    logic [17:0] prev_a;
    logic [7:0]  exp_b[$];

    initial begin
        Resetn = 1'b0; Initialize = 1'b0; Enable = 1'b0;
        Start_address = 18'd0; End_address = 18'd0;
        mem[18'd100]   = 16'hA55A;
        mem[18'd76800] = 16'h0102; mem[18'd76801] = 16'h0304;
        mem[18'd76802] = 16'h0506; mem[18'd76803] = 16'h0708;
        mem[18'h3FFFF] = 16'hFFFF;
        mem[18'd500]   = 16'h1234; mem[18'd600] = 16'hBEEF;
        mem[18'd200]   = 16'h1122; mem[18'd201] = 16'h3344; mem[18'd300] = 16'h5566;
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        check_val("rst_addr", SRAM_address, 18'd0);
        check_val("rst_we_n", SRAM_we_n, 1'b1);
        check_val("rst_tx",   UART_TX_O, 1'b1);
        check_val("rst_busy", Busy, 1'b0);
        check_val("rst_done", Done, 1'b0);
        rx_en = 1'b1;

        // single word
        run_xfer(18'd100, 18'd100, 300, busy_cyc, done_cnt, done_at, first_low, addr_ok, we_ok);
        check_val("single_start_lat", first_low, 4);
        check_val("single_busy_cyc", busy_cyc, 87);
        check_val("single_done_cnt", done_cnt, 1);
        check_val("single_addr", SRAM_address, 18'd100);
        exp_b = '{8'hA5, 8'h5A};
        check_bytes("single", exp_b);

        // four-word range: 4 + 4*82 + 3*5 + 1 busy cycles
        run_xfer(18'd76800, 18'd76803, 600, busy_cyc, done_cnt, done_at, first_low, addr_ok, we_ok);
        check_val("range_busy_cyc", busy_cyc, 348);
        check_val("range_done_cnt", done_cnt, 1);
        check_val("range_addr_step", addr_ok, 1'b1);
        check_val("range_we_n", we_ok, 1'b1);
        check_val("range_final_addr", SRAM_address, 18'd76803);
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        check_bytes("range", exp_b);

        // empty range
        run_xfer(18'd10, 18'd9, 50, busy_cyc, done_cnt, done_at, first_low, addr_ok, we_ok);
        check_val("empty_done_at", done_at, 1);
        check_val("empty_done_cnt", done_cnt, 1);
        check_val("empty_busy_cyc", busy_cyc, 0);
        seen = 0;
        repeat (20) begin
            @(negedge Clock);
            if (UART_TX_O !== 1'b1 || Busy !== 1'b0) seen++;
        end
        check_val("empty_line_idle", seen, 0);
        exp_b = {};
        check_bytes("empty", exp_b);

        // top of memory
        run_xfer(18'h3FFFF, 18'h3FFFF, 300, busy_cyc, done_cnt, done_at, first_low, addr_ok, we_ok);
        check_val("top_done_cnt", done_cnt, 1);
        check_val("top_busy_cyc", busy_cyc, 87);
        check_val("top_addr_nowrap", SRAM_address, 18'h3FFFF);
        exp_b = '{8'hFF, 8'hFF};
        check_bytes("top", exp_b);

        // abort during data bit 3 of the low byte (0x34 bit 3 = 0)
        @(negedge Clock);
        Start_address = 18'd500; End_address = 18'd500; Enable = 1'b1;
        @(negedge Clock);
        Enable = 1'b0;
        repeat (62) @(negedge Clock);
        check_val("abort_midframe_tx", UART_TX_O, 1'b0);
        check_val("abort_midframe_busy", Busy, 1'b1);
        Initialize = 1'b1;
        @(negedge Clock);
        Initialize = 1'b0;
        check_val("abort_tx", UART_TX_O, 1'b1);
        check_val("abort_busy", Busy, 1'b0);
        check_val("abort_addr", SRAM_address, 18'd0);
        check_val("abort_done", Done, 1'b0);
        seen = 0;
        repeat (60) begin
            @(negedge Clock);
            if (Done !== 1'b0 || UART_TX_O !== 1'b1) seen++;
        end
        check_val("abort_quiet", seen, 0);
        rx_q.delete();
        rx_stop_q.delete();
        run_xfer(18'd600, 18'd600, 300, busy_cyc, done_cnt, done_at, first_low, addr_ok, we_ok);
        check_val("restart_start_lat", first_low, 4);
        check_val("restart_done_cnt", done_cnt, 1);
        check_val("restart_addr", SRAM_address, 18'd600);
        exp_b = '{8'hBE, 8'hEF};
        check_bytes("restart", exp_b);

        // Enable held through a 2-word transfer; address changes mid-way are ignored
        @(negedge Clock);
        Start_address = 18'd200; End_address = 18'd201; Enable = 1'b1;
        @(negedge Clock);
        Start_address = 18'd300; End_address = 18'd300;
        busy_cyc = 0; seen = 0; addr_ok = 1'b1; prev_a = SRAM_address;
        for (int c = 1; c <= 400; c++) begin
            if (c > 1) @(negedge Clock);
            if (Busy) busy_cyc++;
            if (SRAM_address != prev_a && SRAM_address != prev_a + 18'd1) addr_ok = 1'b0;
            prev_a = SRAM_address;
            if (Done) begin
                seen = 1;
                break;
            end
        end
        check_val("hold_done", seen, 1);
        check_val("hold_busy_cyc", busy_cyc, 174);
        check_val("hold_no_restart", addr_ok, 1'b1);
        @(negedge Clock);
        Enable = 1'b0;
        check_val("hold_resample_addr", SRAM_address, 18'd300);
        check_val("hold_resample_busy", Busy, 1'b1);
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge Clock);
            if (Done) begin
                seen = 1;
                break;
            end
        end
        check_val("hold_second_done", seen, 1);
        @(negedge Clock);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        check_bytes("hold", exp_b);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_uart_transmit.md
# sram_uart_transmit

Reads a range of 16-bit words from the external SRAM and sends them out the UART TX pin as bytes, high byte first, 8N1, LSB first. It is the upload path that mirrors the UART-to-SRAM loader. It lets the host read back decompressed image data or any other SRAM region. It sits beside the loader on the SRAM address/data mux and owns the bus only while Busy is high.

## Interface
- BAUD_DIVISOR, 434: Clock cycles per UART bit (50 MHz / 115200).
- SRAM_READ_LATENCY, 2: cycles from SRAM_address valid to SRAM_read_data valid. Must be at least 1.
- Clock  in  1  system clock, 50 MHz
- Resetn  in  1  asynchronous, active-low reset
- Initialize  in  1  synchronous abort/clear. Has priority over everything except Resetn.
- Enable  in  1  start request, level-sampled in IDLE
- Start_address  in  18  first word address, sampled on accepted Enable
- End_address  in  18  last word address (inclusive), sampled on accepted Enable
- SRAM_read_data  in  16  SRAM read data
- SRAM_address  out  18  SRAM word address
- SRAM_we_n  out  1  held at 1 (the block never writes)
- UART_TX_O  out  1  serial output, idles high
- Busy  out  1  high from the cycle after Enable is accepted until Done
- Done  out  1  one-cycle pulse after the last stop bit of the last byte

## Operation
- Reset values and Initialize values:
  - SRAM_address = 0, SRAM_we_n = 1, UART_TX_O = 1, Busy = 0, Done = 0.
  - State S_UT_IDLE, serializer idle.
- Initialize mid-frame aborts immediately. UART_TX_O returns high next cycle, the truncated frame is accepted, and Done is not pulsed.
- S_UT_IDLE:
  - When Enable = 1, latch Start/End, drive SRAM_address = Start_address, set Busy, go to S_UT_READ_WAIT.
  - If End_address < Start_address, do not set Busy. Pulse Done the next cycle and stay in IDLE; no bytes are sent.
- S_UT_READ_WAIT: count SRAM_READ_LATENCY cycles, then capture SRAM_read_data into word_buf and go to S_UT_SEND_HIGH.
- S_UT_SEND_HIGH: pulse serializer Load with word_buf[15:8], go to S_UT_WAIT_HIGH.
- S_UT_WAIT_HIGH: when the serializer reports idle (stop bit complete), go to S_UT_SEND_LOW.
- S_UT_SEND_LOW / S_UT_WAIT_LOW: same sequence with word_buf[7:0].
- S_UT_NEXT:
  - If SRAM_address == End_address: clear Busy, pulse Done, go to IDLE.
  - Otherwise SRAM_address += 1 and go to S_UT_READ_WAIT.
  - The address never wraps. End_address = 18'h3FFFF terminates without increment.
- Enable while Busy is ignored. Changing Start/End while Busy has no effect.
- Serializer frame: start bit 0, data[0..7], stop bit 1. Each bit is exactly BAUD_DIVISOR cycles. The baud counter is 16 bits.

## Timing
- UART_TX_O falls (start bit) 2 + SRAM_READ_LATENCY cycles after the Enable-accept edge.
- Frame length is exactly 10*BAUD_DIVISOR cycles.
- Gap between high-byte stop bit end and low-byte start bit: 2 cycles (WAIT→SEND→Load).
- Gap between words: 3 + SRAM_READ_LATENCY cycles of idle-high line.
- Done asserts 1 cycle after the serializer reports idle following the last low byte.
- SRAM_address is stable throughout the read-wait window and changes only in S_UT_NEXT.

## Structure
- The state enum sram_uart_tx_state_type (S_UT_IDLE, S_UT_READ_WAIT, S_UT_SEND_HIGH, S_UT_WAIT_HIGH, S_UT_SEND_LOW, S_UT_WAIT_LOW, S_UT_NEXT) goes in the shared state header alongside the existing UART/SRAM state types.
- Sub-module uart_transmit_controller:
  - Ports: Clock, Resetn, Clear, Load, TX_data[7:0], Empty, UART_TX_O.
  - Parameter: BAUD_DIVISOR.
  - Internal 2-state FSM plus bit and baud counters.
  - Clear is driven by Initialize.

## Test plan
All scenarios use BAUD_DIVISOR = 4 and a behavioral SRAM model with 2-cycle latency.
- Single word: SRAM[100] = 16'hA55A, Start = End = 100, Enable pulse.
  - Line decodes bytes 8'hA5 then 8'h5A.
  - Done pulses once; Busy is high for 2 + 2 + 80 + 2 + 1 cycles.
- Range: SRAM[76800..76803] = 16'h0102, 16'h0304, 16'h0506, 16'h0708.
  - Receiver checker sees 01..08 in order.
  - SRAM_address steps 76800→76803; SRAM_we_n stays 1.
- Empty range: Start = 10, End = 9.
  - No start bit on the line; Done pulses 1 cycle after Enable; Busy stays 0.
- Top of memory: Start = End = 18'h3FFFF with data 16'hFFFF.
  - Two frames are sent and Done pulses.
  - SRAM_address remains 18'h3FFFF and does not wrap to 0.
- Abort: Initialize asserted during bit 3 of the second byte.
  - Next cycle UART_TX_O = 1, Busy = 0, SRAM_address = 0, no Done.
  - A following Enable restarts cleanly from the new Start_address.
- Enable held high during a 2-word transfer: the transfer is not restarted mid-way. After Done, a new transfer begins from the re-sampled Start_address.
